// File: rtl/kvaz_sram_port.sv
// SRAM-side responder for the RAM-disk page mapper: arbitrates paged CPU traffic against
// page-0 video fetches and runs fixed-length strobed accesses to a 512 KB async SRAM.
module kvaz_sram_port #(
    parameter int WAIT_STATES = 2,
    parameter int PAGE_BITS   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [PAGE_BITS-1:0]    cpu_page,
    input  logic [15:0]             cpu_addr,
    input  logic [7:0]              cpu_wdata,
    output logic                    cpu_ack,
    output logic [7:0]              cpu_rdata,
    input  logic                    vid_req,
    input  logic [15:0]             vid_addr,
    output logic                    vid_ack,
    output logic [7:0]              vid_rdata,
    output logic [PAGE_BITS+15:0]   sram_a,
    input  logic [7:0]              sram_dq_i,
    output logic [7:0]              sram_dq_o,
    output logic                    sram_dq_oe,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n
);

    localparam int AW = PAGE_BITS + 16;
    localparam int REQ_CPU = 0;
    localparam int REQ_VID = 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     wait_cnt_reg, wait_cnt_next;
    logic           grant_vid_reg, grant_vid_next;
    logic           last_vid_reg, last_vid_next;
    logic           is_write_reg, is_write_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [7:0]     wdata_reg, wdata_next;
    logic           ce_n_reg, ce_n_next;
    logic           oe_n_reg, oe_n_next;
    logic           we_n_reg, we_n_next;
    logic           dq_oe_reg, dq_oe_next;
    logic           pick_vid;
    logic           capture;

    // Video wins a tie unless it had the previous grant, so a streaming video
    // requester can delay the CPU by at most one access.
    assign pick_vid = vid_req && (!cpu_req || !last_vid_reg);

    // Read data is taken at the edge that ends the final strobe cycle.
    assign capture = (state_reg == ST_ACCESS) && (wait_cnt_reg == 4'd0) && !is_write_reg;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        grant_vid_next = grant_vid_reg;
        last_vid_next  = last_vid_reg;
        is_write_next  = is_write_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req || vid_req) begin
                    state_next     = ST_SETUP;
                    grant_vid_next = pick_vid;
                    last_vid_next  = pick_vid;
                    if (pick_vid) begin
                        is_write_next = 1'b0;
                        addr_next     = {{PAGE_BITS{1'b0}}, vid_addr};
                    end else begin
                        is_write_next = cpu_we;
                        addr_next     = {cpu_page, cpu_addr};
                        wdata_next    = cpu_wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_next    = ST_ACCESS;
                wait_cnt_next = WAIT_LOAD;
            end
            ST_ACCESS: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_HOLD;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_HOLD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Pin controls are registered from the next state so they are glitch-free
        // and line up exactly with the state they belong to.
        ce_n_next  = (state_next == ST_IDLE);
        oe_n_next  = !(!is_write_next &&
                       ((state_next == ST_SETUP) || (state_next == ST_ACCESS)));
        we_n_next  = !(is_write_next && (state_next == ST_ACCESS));
        dq_oe_next = is_write_next && (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            grant_vid_reg <= 1'b0;
            last_vid_reg  <= 1'b0;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 8'h00;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            dq_oe_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            grant_vid_reg <= grant_vid_next;
            last_vid_reg  <= last_vid_next;
            is_write_reg  <= is_write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            ce_n_reg      <= ce_n_next;
            oe_n_reg      <= oe_n_next;
            we_n_reg      <= we_n_next;
            dq_oe_reg     <= dq_oe_next;
        end
    end

    // Per-requester ack pulse and read-data holding register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic       ack_reg, ack_next;
        logic [7:0] rdata_reg, rdata_next;
        logic       is_owner;

        assign is_owner   = (grant_vid_next == 1'(gi));
        assign ack_next   = (state_next == ST_HOLD) && is_owner;
        assign rdata_next = (capture && (grant_vid_reg == 1'(gi))) ? sram_dq_i : rdata_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                ack_reg   <= 1'b0;
                rdata_reg <= 8'h00;
            end else begin
                ack_reg   <= ack_next;
                rdata_reg <= rdata_next;
            end
        end
    end

    assign cpu_ack    = g_req[REQ_CPU].ack_reg;
    assign cpu_rdata  = g_req[REQ_CPU].rdata_reg;
    assign vid_ack    = g_req[REQ_VID].ack_reg;
    assign vid_rdata  = g_req[REQ_VID].rdata_reg;

    assign sram_a     = addr_reg;
    assign sram_dq_o  = wdata_reg;
    assign sram_dq_oe = dq_oe_reg;
    assign sram_ce_n  = ce_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign sram_we_n  = we_n_reg;

endmodule

// File: tb/tb_kvaz_sram_port.sv
// Scoreboard bench for kvaz_sram_port: drives CPU/video requesters against a behavioural
// async SRAM and checks every acknowledged access against an expected-transaction queue.
module tb_kvaz_sram_port;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_page = 3'd0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = 16'h0000;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic [18:0] sram_a;
    logic [7:0]  sram_dq_i;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    kvaz_sram_port #(.WAIT_STATES(WS), .PAGE_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_page   (cpu_page),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .sram_a     (sram_a),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural async SRAM; 8'hFF on the bus when not output-enabled.
    logic [7:0] mem [0:524287];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_a] <= sram_dq_o;
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'hFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        vid;
        logic        we;
        logic [18:0] a;
        logic [7:0]  d;
    } txn_t;

    txn_t exp_q[$];

    function automatic txn_t mk(input logic vid, input logic we, input logic [18:0] a,
                                input logic [7:0] d);
        txn_t t;
        t.vid = vid;
        t.we  = we;
        t.a   = a;
        t.d   = d;
        return t;
    endfunction

    // Access monitor: records each access from the falling ce_n, then scores it at the ack.
    logic        in_acc = 1'b0;
    logic [18:0] acc_a = '0;
    logic        acc_we = 1'b0;
    logic        acc_bad = 1'b0;
    int          acc_start = 0;
    int          we_cnt = 0;
    int          oe_cnt = 0;
    int          cpu_ack_len = 0;
    int          vid_ack_len = 0;

    always @(negedge clk) begin
        if (reset || sram_ce_n) begin
            in_acc = 1'b0;
        end else begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                acc_a     = sram_a;
                acc_we    = sram_dq_oe;
                acc_bad   = 1'b0;
                acc_start = cyc;
                we_cnt    = 0;
                oe_cnt    = 0;
            end
            if (!sram_we_n) we_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n && !sram_oe_n) acc_bad = 1'b1;
            if (sram_dq_oe && !sram_oe_n) acc_bad = 1'b1;
        end

        if (cpu_ack) cpu_ack_len++;
        else if (cpu_ack_len != 0) begin
            check("cpu_ack_width", 32'(cpu_ack_len), 32'd1);
            cpu_ack_len = 0;
        end
        if (vid_ack) vid_ack_len++;
        else if (vid_ack_len != 0) begin
            check("vid_ack_width", 32'(vid_ack_len), 32'd1);
            vid_ack_len = 0;
        end

        if (!reset && (cpu_ack || vid_ack)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, vid_ack, cpu_ack}, 32'd0);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                check("ack_owner", {30'd0, vid_ack, cpu_ack}, e.vid ? 32'd2 : 32'd1);
                check("sram_a", 32'(acc_a), 32'(e.a));
                check("direction", 32'(acc_we), 32'(e.we));
                check("latency", 32'(cyc - acc_start), 32'(WS + 1));
                check("strobe_overlap", 32'(acc_bad), 32'd0);
                if (e.we) begin
                    check("we_low_cycles", 32'(we_cnt), 32'(WS));
                    check("mem_written", 32'(mem[e.a]), 32'(e.d));
                end else begin
                    check("oe_low_cycles", 32'(oe_cnt), 32'(WS + 1));
                    check("rdata", 32'(e.vid ? vid_rdata : cpu_rdata), 32'(e.d));
                end
                $display("txn %s %s a=%05h d=%02h done at cycle %0d",
                         e.vid ? "VID" : "CPU", e.we ? "WR" : "RD", e.a, e.d, cyc);
            end
        end
    end

    // CPU requester: holds req through n_acks acknowledgements (back-to-back when n_acks>1).
    task automatic cpu_access(input logic we, input logic [2:0] page, input logic [15:0] addr,
                              input logic [7:0] d, input int n_acks,
                              output int first_cyc, output int last_cyc);
        int t;
        first_cyc = 0;
        last_cyc  = 0;
        @(negedge clk);
        cpu_we    = we;
        cpu_page  = page;
        cpu_addr  = addr;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        for (int k = 0; k < n_acks; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!cpu_ack && t < 200);
            if (!cpu_ack) begin
                check("cpu_ack_timeout", 32'd0, 32'd1);
                break;
            end
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        cpu_req = 1'b0;
    endtask

    task automatic vid_access(input logic [15:0] addr, input int n_acks);
        int t;
        @(negedge clk);
        vid_addr = addr;
        vid_req  = 1'b1;
        for (int k = 0; k < n_acks; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!vid_ack && t < 200);
            if (!vid_ack) begin
                check("vid_ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
        vid_req = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
        check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, "_acks"}, {30'd0, vid_ack, cpu_ack}, 32'd0);
        check({tag, "_sram_a"}, 32'(sram_a), 32'd0);
        check({tag, "_dq_o"}, 32'(sram_dq_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, t;

        repeat (3) @(negedge clk);
        check_idle_pins("reset");
        check("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("reset_vid_rdata", 32'(vid_rdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Paged CPU write then read-back.
        exp_q.push_back(mk(1'b0, 1'b1, 19'h3A123, 8'h5A));
        cpu_access(1'b1, 3'd3, 16'hA123, 8'h5A, 1, f, l);
        exp_q.push_back(mk(1'b0, 1'b0, 19'h3A123, 8'h5A));
        cpu_access(1'b0, 3'd3, 16'hA123, 8'h00, 1, f, l);

        // Preload data for the arbitration tests.
        exp_q.push_back(mk(1'b0, 1'b1, 19'h08000, 8'hC3));
        cpu_access(1'b1, 3'd0, 16'h8000, 8'hC3, 1, f, l);
        exp_q.push_back(mk(1'b0, 1'b1, 19'h10000, 8'h3C));
        cpu_access(1'b1, 3'd1, 16'h0000, 8'h3C, 1, f, l);
        exp_q.push_back(mk(1'b0, 1'b1, 19'h08001, 8'h77));
        cpu_access(1'b1, 3'd0, 16'h8001, 8'h77, 1, f, l);
        exp_q.push_back(mk(1'b0, 1'b1, 19'h24444, 8'h99));
        cpu_access(1'b1, 3'd2, 16'h4444, 8'h99, 1, f, l);
        exp_q.push_back(mk(1'b0, 1'b1, 19'h20010, 8'h42));
        cpu_access(1'b1, 3'd2, 16'h0010, 8'h42, 1, f, l);

        // Simultaneous requests after a CPU grant: video first, then CPU.
        exp_q.push_back(mk(1'b1, 1'b0, 19'h08000, 8'hC3));
        exp_q.push_back(mk(1'b0, 1'b0, 19'h10000, 8'h3C));
        fork
            vid_access(16'h8000, 1);
            cpu_access(1'b0, 3'd1, 16'h0000, 8'h00, 1, f, l);
        join

        // Continuous video with a pending CPU read: VID, CPU, VID.
        exp_q.push_back(mk(1'b1, 1'b0, 19'h08001, 8'h77));
        exp_q.push_back(mk(1'b0, 1'b0, 19'h24444, 8'h99));
        exp_q.push_back(mk(1'b1, 1'b0, 19'h08001, 8'h77));
        fork
            vid_access(16'h8001, 2);
            cpu_access(1'b0, 3'd2, 16'h4444, 8'h00, 1, f, l);
        join

        // Reset while a write strobe is active: pins return to idle, no ack.
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_page = 3'd5;
        cpu_addr = 16'h1111;
        cpu_wdata = 8'hEE;
        cpu_req = 1'b1;
        t = 0;
        while (sram_we_n && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("we_strobe_seen", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check_idle_pins("abort");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_ack", {30'd0, vid_ack, cpu_ack}, 32'd0);

        exp_q.push_back(mk(1'b0, 1'b0, 19'h3A123, 8'h5A));
        cpu_access(1'b0, 3'd3, 16'hA123, 8'h00, 1, f, l);

        // Back-to-back CPU reads with req held through the ack.
        exp_q.push_back(mk(1'b0, 1'b0, 19'h20010, 8'h42));
        exp_q.push_back(mk(1'b0, 1'b0, 19'h20010, 8'h42));
        cpu_access(1'b0, 3'd2, 16'h0010, 8'h00, 2, f, l);
        check("b2b_period", 32'(l - f), 32'(WS + 3));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
